// File: rtl/qa_drv_hc_issue_throttle.sv
// rtl/qa_drv_hc_issue_throttle.sv - per-channel issue throttle with almostfull slack, release hysteresis and in-flight cap
module qa_drv_hc_issue_throttle #(
    parameter int N_CHANNELS      = 2,
    parameter int CAN_ISSUE_FULL  = 4,
    parameter int RELEASE_DELAY   = 0,
    parameter int MAX_OUTSTANDING = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CHANNELS-1:0] almostfull,
    input  logic [N_CHANNELS-1:0] issue,
    input  logic [N_CHANNELS-1:0] rsp,
    output logic [N_CHANNELS-1:0] can_issue,
    output logic [N_CHANNELS-1:0] error
);

    localparam int SW = (CAN_ISSUE_FULL > 0) ? $clog2(CAN_ISSUE_FULL + 1) : 1;
    localparam int OW = (MAX_OUTSTANDING > 0) ? $clog2(MAX_OUTSTANDING + 1) : 1;
    localparam logic [SW-1:0] SLACK_MAX  = SW'(CAN_ISSUE_FULL);
    localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
    localparam logic [7:0]    TIMER_LOAD = (RELEASE_DELAY > 0) ? 8'(RELEASE_DELAY - 1) : 8'd0;
    localparam bit            HYST       = (RELEASE_DELAY > 0);
    localparam bit            CAP        = (MAX_OUTSTANDING > 0);

    localparam logic [1:0] ST_OPEN    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_ch
        logic          af_ff;
        logic [1:0]    state;
        logic [1:0]    state_nxt;
        logic [SW-1:0] slack;
        logic [7:0]    timer;
        logic [OW-1:0] out_cnt;
        logic          err;
        logic          gate;
        logic          out_ok;
        logic          acc;

        // While almostfull is registered high only the slack budget matters;
        // otherwise the FSM decides whether the channel has re-opened yet.
        always_comb begin
            gate = 1'b0;
            if (af_ff) begin
                gate = (slack < SLACK_MAX);
            end else begin
                gate = (state == ST_OPEN) || ((state == ST_HOLD) && !HYST);
            end
        end

        assign out_ok        = !CAP || (out_cnt < OUT_MAX);
        assign can_issue[ch] = gate & out_ok;
        assign acc           = issue[ch] & can_issue[ch];
        assign error[ch]     = err;

        always_comb begin
            state_nxt = state;
            case (state)
                ST_OPEN: begin
                    if (af_ff) state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!af_ff) state_nxt = HYST ? ST_RELEASE : ST_OPEN;
                end
                ST_RELEASE: begin
                    if (af_ff)            state_nxt = ST_HOLD;
                    else if (timer == 0)  state_nxt = ST_OPEN;
                end
                default: state_nxt = ST_OPEN;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                af_ff   <= 1'b0;
                state   <= ST_OPEN;
                slack   <= '0;
                timer   <= '0;
                out_cnt <= '0;
                err     <= 1'b0;
            end else begin
                af_ff <= almostfull[ch];
                state <= state_nxt;

                // Slack survives RELEASE->HOLD bounces; only a full re-open refunds it.
                if ((state_nxt == ST_OPEN) && (state != ST_OPEN)) begin
                    slack <= '0;
                end else if (acc && af_ff && (slack < SLACK_MAX)) begin
                    slack <= slack + 1'b1;
                end

                if ((state == ST_HOLD) && (state_nxt == ST_RELEASE)) begin
                    timer <= TIMER_LOAD;
                end else if ((state == ST_RELEASE) && (state_nxt == ST_RELEASE)) begin
                    timer <= timer - 1'b1;
                end

                if (CAP) begin
                    if (acc && !rsp[ch] && (out_cnt < OUT_MAX)) begin
                        out_cnt <= out_cnt + 1'b1;
                    end else if (rsp[ch] && !acc && (out_cnt != 0)) begin
                        out_cnt <= out_cnt - 1'b1;
                    end
                end

                if ((issue[ch] && !can_issue[ch]) ||
                    (CAP && rsp[ch] && !acc && (out_cnt == 0))) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qa_drv_hc_issue_throttle.sv
// tb/tb_qa_drv_hc_issue_throttle.sv - scoreboard bench for qa_drv_hc_issue_throttle
module tb_qa_drv_hc_issue_throttle;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] a_af, a_issue, a_rsp, a_ci, a_err;
    logic [1:0] b_af, b_issue, b_rsp, b_ci, b_err;
    logic [1:0] c_af, c_issue, c_rsp, c_ci, c_err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         sel;
        logic [1:0] exp;
        string      tag;
    } sb_t;
    sb_t sb_q[$];

    localparam int A_CI = 0, A_ERR = 1, B_CI = 2, B_ERR = 3, C_CI = 4, C_ERR = 5;

    always #5 clk = ~clk;

    qa_drv_hc_issue_throttle #(.N_CHANNELS(2), .CAN_ISSUE_FULL(0), .RELEASE_DELAY(0), .MAX_OUTSTANDING(0)) u_a (
        .clk(clk), .reset(reset), .almostfull(a_af), .issue(a_issue), .rsp(a_rsp),
        .can_issue(a_ci), .error(a_err));

    qa_drv_hc_issue_throttle #(.N_CHANNELS(2), .CAN_ISSUE_FULL(4), .RELEASE_DELAY(3), .MAX_OUTSTANDING(0)) u_b (
        .clk(clk), .reset(reset), .almostfull(b_af), .issue(b_issue), .rsp(b_rsp),
        .can_issue(b_ci), .error(b_err));

    qa_drv_hc_issue_throttle #(.N_CHANNELS(2), .CAN_ISSUE_FULL(4), .RELEASE_DELAY(0), .MAX_OUTSTANDING(2)) u_c (
        .clk(clk), .reset(reset), .almostfull(c_af), .issue(c_issue), .rsp(c_rsp),
        .can_issue(c_ci), .error(c_err));

    function automatic logic [1:0] obs(input int sel);
        case (sel)
            A_CI:    return a_ci;
            A_ERR:   return a_err;
            B_CI:    return b_ci;
            B_ERR:   return b_err;
            C_CI:    return c_ci;
            default: return c_err;
        endcase
    endfunction

    task automatic push(input int sel, input logic [1:0] exp, input string tag);
        sb_t e;
        e.sel = sel;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic chk();
        sb_t e;
        logic [1:0] o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs(e.sel);
            n_cmp++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chk();
    endtask

    initial begin
        reset = 1'b1;
        {a_af, a_issue, a_rsp} = '0;
        {b_af, b_issue, b_rsp} = '0;
        {c_af, c_issue, c_rsp} = '0;
        #3;
        push(A_CI, 2'b11, "rst_a_ci");  push(A_ERR, 2'b00, "rst_a_err");
        push(B_CI, 2'b11, "rst_b_ci");  push(B_ERR, 2'b00, "rst_b_err");
        push(C_CI, 2'b11, "rst_c_ci");  push(C_ERR, 2'b00, "rst_c_err");
        chk();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) cyc();

        // Legacy: can_issue[0] follows ~af_ff, four blocked cycles
        a_af = 2'b01;
        push(A_CI, 2'b11, "leg_pre");
        chk();
        for (int i = 0; i < 4; i++) begin
            push(A_CI, 2'b10, "leg_blocked");
            cyc();
        end
        a_af = 2'b00;
        push(A_CI, 2'b11, "leg_reopen");
        cyc();
        push(A_CI, 2'b11, "leg_open");
        cyc();

        // Issue while blocked sets sticky error
        a_af = 2'b10;
        push(A_CI, 2'b01, "leg_ch1_blk");
        cyc();
        a_issue = 2'b10;
        push(A_ERR, 2'b00, "err_pre");
        chk();
        push(A_ERR, 2'b10, "err_set");
        cyc();
        a_issue = 2'b00;
        a_af    = 2'b00;
        push(A_ERR, 2'b10, "err_sticky1");
        cyc();
        push(A_CI, 2'b11, "err_ci_back");
        push(A_ERR, 2'b10, "err_sticky2");
        cyc();

        // Slack: four accepts after af_ff rises, then blocked
        b_af    = 2'b01;
        b_issue = 2'b01;
        push(B_CI, 2'b11, "slk_pre");
        chk();
        for (int i = 0; i < 4; i++) begin
            push(B_CI, 2'b11, "slk_accept");
            cyc();
        end
        push(B_CI, 2'b10, "slk_exhaust");
        cyc();
        b_issue = 2'b00;
        push(B_ERR, 2'b00, "slk_no_err");
        chk();
        push(B_CI, 2'b10, "slk_hold");
        cyc();

        // Hysteresis with re-assert during RELEASE, then full release
        b_af = 2'b00;
        push(B_CI, 2'b10, "hys_hold_af0");
        cyc();
        push(B_CI, 2'b10, "hys_rel_t2");
        cyc();
        b_af = 2'b01;
        push(B_CI, 2'b10, "hys_reassert_slack_kept");
        cyc();
        push(B_CI, 2'b10, "hys_back_hold");
        cyc();
        b_af = 2'b00;
        for (int i = 0; i < 4; i++) begin
            push(B_CI, 2'b10, "hys_release_blk");
            cyc();
        end
        push(B_CI, 2'b11, "hys_open");
        cyc();

        // Build B ch1 to HOLD with slack=3
        b_af    = 2'b10;
        b_issue = 2'b10;
        push(B_CI, 2'b11, "b1_pre");
        chk();
        for (int i = 0; i < 4; i++) begin
            push(B_CI, 2'b11, "b1_accept");
            cyc();
        end
        b_issue = 2'b00;
        push(B_ERR, 2'b00, "b1_no_err");
        chk();

        // Outstanding cap on C ch0
        c_issue = 2'b01;
        push(C_CI, 2'b11, "cap_pre");
        chk();
        push(C_CI, 2'b11, "cap_one");
        cyc();
        push(C_CI, 2'b10, "cap_full");
        cyc();
        c_issue = 2'b00;
        c_rsp   = 2'b01;
        push(C_CI, 2'b11, "cap_rsp_frees");
        cyc();
        c_issue = 2'b01;
        push(C_CI, 2'b11, "cap_acc_rsp_keep");
        cyc();
        c_rsp = 2'b00;
        push(C_CI, 2'b10, "cap_full_again");
        cyc();
        c_issue = 2'b00;
        push(C_ERR, 2'b00, "cap_no_err");
        chk();

        // Response underflow on C ch1
        c_rsp = 2'b10;
        push(C_ERR, 2'b00, "uf_pre");
        chk();
        push(C_ERR, 2'b10, "uf_err");
        cyc();
        c_rsp   = 2'b00;
        c_issue = 2'b10;
        push(C_CI, 2'b10, "uf_cnt_zero");
        chk();
        push(C_CI, 2'b10, "uf_one");
        cyc();
        push(C_CI, 2'b00, "uf_two_full");
        cyc();
        c_issue = 2'b00;
        push(C_ERR, 2'b10, "uf_sticky");
        push(C_CI, 2'b00, "uf_still_full");
        cyc();

        // Async reset mid-operation, checked before any clock edge
        b_af = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        push(A_CI, 2'b11, "arst_a_ci");  push(A_ERR, 2'b00, "arst_a_err");
        push(B_CI, 2'b11, "arst_b_ci");  push(B_ERR, 2'b00, "arst_b_err");
        push(C_CI, 2'b11, "arst_c_ci");  push(C_ERR, 2'b00, "arst_c_err");
        chk();
        #2;
        reset = 1'b0;
        push(C_CI, 2'b11, "post_rst_c_ci");
        push(B_CI, 2'b11, "post_rst_b_ci");
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
